// File: rtl/univ_bin_counter.sv
// -----------------------------------------------------------------------------
// univ_bin_counter
//
// Purpose:
//   Parameterised N-bit universal binary counter with synchronous clear,
//   parallel load, count enable and up/down direction. Counting wraps modulo
//   2^N by default. Combinational terminal-count flags report when the count
//   sits at all ones (max_tick) or at zero (min_tick).
//
// Build option:
//   UNIV_BIN_COUNTER_SAT_EN - when defined, counting saturates at 2^N-1 (up)
//                             and at 0 (down) instead of wrapping. Clear, load
//                             and the flags are unaffected.
//
// Parameters:
//   N         counter width in bits, 1..32 (default 8)
//
// Ports:
//   clk       in   1  system clock, rising-edge active
//   reset     in   1  asynchronous active-high reset, forces q to 0
//   syn_clr   in   1  synchronous clear (highest synchronous priority)
//   load      in   1  synchronous parallel load of d
//   en        in   1  count enable
//   up        in   1  direction: 1 = increment, 0 = decrement
//   d         in   N  parallel load value
//   max_tick  out  1  high while q == 2^N-1
//   min_tick  out  1  high while q == 0
//   q         out  N  current count (registered)
// -----------------------------------------------------------------------------
module univ_bin_counter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         syn_clr,
    input  logic         load,
    input  logic         en,
    input  logic         up,
    input  logic [N-1:0] d,
    output logic         max_tick,
    output logic         min_tick,
    output logic [N-1:0] q
);

    localparam logic [N-1:0] CNT_MAX = '1;
    localparam logic [N-1:0] CNT_MIN = '0;
    localparam logic [N-1:0] CNT_ONE = N'(1);

    // Next value when counting up; wraps to 0 unless saturation is built in.
    function automatic logic [N-1:0] step_up(input logic [N-1:0] cur);
`ifdef UNIV_BIN_COUNTER_SAT_EN
        if (cur == CNT_MAX) return cur;
`endif
        return cur + CNT_ONE;
    endfunction

    // Next value when counting down; wraps to all ones unless saturating.
    function automatic logic [N-1:0] step_down(input logic [N-1:0] cur);
`ifdef UNIV_BIN_COUNTER_SAT_EN
        if (cur == CNT_MIN) return cur;
`endif
        return cur - CNT_ONE;
    endfunction

    logic [N-1:0] q_p0;

    // Stage p0: count register, clear > load > count > hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_p0 <= CNT_MIN;
        end else if (syn_clr) begin
            q_p0 <= CNT_MIN;
        end else if (load) begin
            q_p0 <= d;
        end else if (en) begin
            q_p0 <= up ? step_up(q_p0) : step_down(q_p0);
        end
    end

    assign q        = q_p0;
    assign max_tick = (q_p0 == CNT_MAX);
    assign min_tick = (q_p0 == CNT_MIN);

endmodule

// File: tb/tb_univ_bin_counter.sv
module tb_univ_bin_counter;

    localparam int N = 3;

`ifdef UNIV_BIN_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         syn_clr;
    logic         load;
    logic         en;
    logic         up;
    logic [N-1:0] d;
    logic         max_tick;
    logic         min_tick;
    logic [N-1:0] q;

    int checks   = 0;
    int failures = 0;

    univ_bin_counter #(.N(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .syn_clr  (syn_clr),
        .load     (load),
        .en       (en),
        .up       (up),
        .d        (d),
        .max_tick (max_tick),
        .min_tick (min_tick),
        .q        (q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         sc;
        logic         ld;
        logic         e;
        logic         u;
        logic [N-1:0] dv;
        logic [N-1:0] exp_q;
        logic         exp_max;
        logic         exp_min;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic sc, input logic ld, input logic e, input logic u,
                       input logic [N-1:0] dv, input logic [N-1:0] qv,
                       input logic mx, input logic mn);
        vec_t v;
        v.sc = sc; v.ld = ld; v.e = e; v.u = u; v.dv = dv;
        v.exp_q = qv; v.exp_max = mx; v.exp_min = mn;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string nm, input logic [N-1:0] eq,
                           input logic emx, input logic emn);
        chk({nm, " q"}, 32'(q), 32'(eq));
        chk({nm, " max_tick"}, 32'(max_tick), 32'(emx));
        chk({nm, " min_tick"}, 32'(min_tick), 32'(emn));
    endtask

    task automatic drive(input logic sc, input logic ld, input logic e, input logic u,
                         input logic [N-1:0] dv);
        syn_clr = sc; load = ld; en = e; up = u; d = dv;
    endtask

    // One edge with the given controls, sampled 1 time unit after the edge.
    task automatic step(input logic sc, input logic ld, input logic e, input logic u,
                        input logic [N-1:0] dv);
        @(negedge clk);
        drive(sc, ld, e, u, dv);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- vector table ----------------
        //   sc ld en up d   q  max min
        add(0, 0, 0, 0, 0, 0, 0, 1);   // idle after reset
        add(0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 1, 0, 0, 3, 3, 0, 0);   // load 3
        add(0, 0, 0, 0, 0, 3, 0, 0);   // hold
        add(0, 0, 0, 0, 0, 3, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 1);   // sync clear
        add(0, 1, 0, 0, 3, 3, 0, 0);
        add(1, 1, 1, 1, 5, 0, 0, 1);   // clear beats load and count
        // count up 10 edges: 1..7,0,1,2
        add(0, 0, 1, 1, 0, 1, 0, 0);
        add(0, 0, 1, 1, 0, 2, 0, 0);
        add(0, 0, 1, 1, 0, 3, 0, 0);
        add(0, 0, 1, 1, 0, 4, 0, 0);
        add(0, 0, 1, 1, 0, 5, 0, 0);
        add(0, 0, 1, 1, 0, 6, 0, 0);
        add(0, 0, 1, 1, 0, 7, 1, 0);
        add(0, 0, 1, 1, 0, 0, 0, 1);   // wraps 7 -> 0
        add(0, 0, 1, 1, 0, 1, 0, 0);
        add(0, 0, 1, 1, 0, 2, 0, 0);
        add(0, 0, 0, 1, 0, 2, 0, 0);   // frozen
        add(0, 0, 0, 0, 0, 2, 0, 0);
        add(0, 0, 1, 1, 0, 3, 0, 0);
        add(0, 0, 1, 1, 0, 4, 0, 0);
        // count down 10 edges: 3,2,1,0,7,6,5,4,3,2
        add(0, 0, 1, 0, 0, 3, 0, 0);
        add(0, 0, 1, 0, 0, 2, 0, 0);
        add(0, 0, 1, 0, 0, 1, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 1);
        add(0, 0, 1, 0, 0, 7, 1, 0);   // wraps 0 -> 7
        add(0, 0, 1, 0, 0, 6, 0, 0);
        add(0, 0, 1, 0, 0, 5, 0, 0);
        add(0, 0, 1, 0, 0, 4, 0, 0);
        add(0, 0, 1, 0, 0, 3, 0, 0);
        add(0, 0, 1, 0, 0, 2, 0, 0);
        add(0, 0, 1, 1, 0, 3, 0, 0);   // direction change, no dead cycle
        add(0, 1, 1, 0, 6, 6, 0, 0);   // load beats count
        add(0, 0, 1, 0, 0, 5, 0, 0);

        // ---------------- reset ----------------
        drive(0, 0, 0, 0, 0);
        reset = 1'b1;
        #2;
        chk_all("reset", 0, 0, 1);
        @(negedge clk);
        reset = 1'b0;

        // ---------------- table ----------------
        foreach (vecs[i]) begin
            step(vecs[i].sc, vecs[i].ld, vecs[i].e, vecs[i].u, vecs[i].dv);
            chk_all($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_max, vecs[i].exp_min);
        end

        // ---------------- down past zero ----------------
        step(0, 1, 0, 0, 2);
        chk_all("down load2", 2, 0, 0);
        step(0, 0, 1, 0, 0);
        chk_all("down 1", 1, 0, 0);
        step(0, 0, 1, 0, 0);
        chk_all("down 0", 0, 0, 1);
        step(0, 0, 1, 0, 0);
        if (SAT) chk_all("down past 0", 0, 0, 1);
        else     chk_all("down past 0", 7, 1, 0);

        // ---------------- up past max ----------------
        step(0, 1, 0, 0, 7);
        chk_all("up load7", 7, 1, 0);
        step(0, 0, 1, 1, 0);
        if (SAT) chk_all("up past 7", 7, 1, 0);
        else     chk_all("up past 7", 0, 0, 1);

        // ---------------- async reset mid-count ----------------
        step(1, 0, 0, 0, 0);
        chk_all("pre-async clr", 0, 0, 1);
        step(0, 0, 1, 1, 0);
        chk_all("pre-async 1", 1, 0, 0);
        step(0, 0, 1, 1, 0);
        chk_all("pre-async 2", 2, 0, 0);
        #2;
        reset = 1'b1;              // between edges, en still high
        #1;
        chk_all("async reset", 0, 0, 1);
        @(posedge clk);
        #1;
        chk_all("reset held", 0, 0, 1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk_all("post-reset 1", 1, 0, 0);
        @(posedge clk);
        #1;
        chk_all("post-reset 2", 2, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time bound so the bench can never hang.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/univ_bin_counter.md
Name: univ_bin_counter

Overview:
Parameterised N-bit universal binary counter: synchronous clear, parallel load, enable, and up/down counting with natural wrap-around. It also drives combinational terminal-count flags for max and min. It is a generic building block for timers, address generators and loop counters, used in a single clock domain.

Parameters:
N, 8, counter width in bits; legal range 1..32.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset; forces q to 0 immediately.
syn_clr  input  1  synchronous clear; highest synchronous priority.
load  input  1  synchronous parallel load of d.
en  input  1  count enable.
up  input  1  direction: 1 = increment, 0 = decrement.
d  input  N  parallel load value.
max_tick  output  1  high while q equals all ones (2^N-1).
min_tick  output  1  high while q equals 0.
q  output  N  current count (registered).

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high.
- Reset: while reset=1, q=0, so max_tick=0 (for N>=1) and min_tick=1. Reset asserted mid-count clears q without waiting for a clock edge. Counting resumes on the first rising edge after reset deasserts.
- Synchronous update on each rising clk edge when reset=0 uses this fixed priority:
  1. syn_clr=1: q <= 0. Overrides load and en.
  2. load=1: q <= d. Overrides en and up.
  3. en=1 and up=1: q <= q+1, modulo 2^N (2^N-1 wraps to 0).
  4. en=1 and up=0: q <= q-1, modulo 2^N (0 wraps to 2^N-1).
  5. Otherwise q holds.
- Latency: every control takes effect on the edge that samples it, so q changes one cycle after the control is applied. Inputs have no pipeline.
- Flags: max_tick = (q == 2^N-1) and min_tick = (q == 0). Both are purely combinational from q, independent of en and up, with no extra latency.
- Both flags are 1 only when N... not applicable: for N>=1 at most one flag is high at a time.
- Changing up while en=1 takes effect at the next edge; no dead cycle.
- load with d wider values: d is exactly N bits, so there is no truncation.
- All arithmetic is unsigned N-bit with no carry-out port.

Optional Feature:
- Macro: UNIV_BIN_COUNTER_SAT_EN.
- Defined: the counter saturates instead of wrapping.
  - en=1, up=1 at q=2^N-1 holds q.
  - en=1, up=0 at q=0 holds q.
  - syn_clr, load and the flags behave as in wrap mode.
- Not defined: modulo wrap-around as specified above (default).

Test Plan:
- N=3; assert reset for half a cycle, then release with all controls 0 -> q=0, min_tick=1, max_tick=0; q remains 0 over idle cycles.
- load=1, d=3 for one edge, then load=0 with en=0 for 2 cycles -> q=3 and holds at 3. Then syn_clr=1 for one edge -> q=0. syn_clr=1 together with load=1 and d=5 -> q=0 (clear wins).
- en=1, up=1 for 10 edges from 0 -> sequence 1..7,0,1,2 ending at q=2. max_tick=1 exactly in the cycle q=7; min_tick=1 in the cycle q=0.
- en=0 for 2 edges -> q frozen. en=1 for 2 edges -> q+2. up=0 for 10 edges -> decrements and wraps 0->7. Continue down to q=2, then switch up=1 -> next value 3.
- Run down until min_tick=1 (q=0), then one more down edge -> q=7 and max_tick=1. With UNIV_BIN_COUNTER_SAT_EN defined, the same stimulus instead keeps q=0. Likewise, up-counting at q=7 stays at 7 when the macro is defined.
- Assert reset asynchronously mid-count (between clock edges) with en=1 -> q goes to 0 before the next edge. Release reset -> counting restarts from 0 on the next rising edge.
